// File: rtl/score_tracker.sv
// Multi-player saturating score engine with per-player combo multipliers,
// session high score, leader tracking and end-of-round score hold.
module score_tracker #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NPLAY     = 2,
   parameter int unsigned COMBO_MAX = 4,
   localparam int unsigned MW       = $clog2(COMBO_MAX + 1),
   localparam int unsigned LW       = (NPLAY > 1) ? $clog2(NPLAY) : 1
) (
   input  logic                   clkIn,
   input  logic                   reset,
   input  logic                   game_active,
   input  logic [NPLAY-1:0]       player_scored,
   input  logic [NPLAY-1:0]       player_missed,
   output logic [NPLAY*WIDTH-1:0] score,
   output logic [NPLAY*MW-1:0]    combo,
   output logic [LW-1:0]          leader,
   output logic [WIDTH-1:0]       high_score,
   output logic                   new_high,
   output logic                   game_over
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StPlay   = 2'd1;
   localparam logic [1:0] StSettle = 2'd2;
   localparam logic [1:0] StShow   = 2'd3;

   localparam logic [WIDTH-1:0] ScoreMax = '1;
   localparam logic [MW-1:0]    ComboMax = MW'(COMBO_MAX);
   localparam logic [MW-1:0]    ComboOne = MW'(1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] score_q [NPLAY];
   logic [WIDTH-1:0] score_d [NPLAY];
   logic [MW-1:0]    combo_q [NPLAY];
   logic [MW-1:0]    combo_d [NPLAY];
   logic [WIDTH:0]   sum     [NPLAY];
   logic [LW-1:0]    leader_q, leader_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [WIDTH-1:0] round_max;
   logic             new_high_q, new_high_d;

   // One extra bit on the adder catches overflow for the clamp.
   always_comb begin
      for (int unsigned i = 0; i < NPLAY; i++) begin
         sum[i] = {1'b0, score_q[i]} + (WIDTH+1)'(combo_q[i]);
      end
   end

   // Strict '>' keeps the lowest index on ties; the same search yields the round maximum.
   always_comb begin
      leader_d  = '0;
      round_max = score_q[0];
      for (int unsigned i = 1; i < NPLAY; i++) begin
         if (score_q[i] > round_max) begin
            round_max = score_q[i];
            leader_d  = LW'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      score_d    = score_q;
      combo_d    = combo_q;
      high_d     = high_q;
      new_high_d = 1'b0;
      case (state_q)
         StIdle, StShow: begin
            if (game_active) begin
               state_d = StPlay;
               for (int unsigned i = 0; i < NPLAY; i++) begin
                  score_d[i] = '0;
                  combo_d[i] = ComboOne;
               end
            end
         end
         StPlay: begin
            if (!game_active) begin
               state_d = StSettle;
            end else begin
               for (int unsigned i = 0; i < NPLAY; i++) begin
                  if (player_scored[i]) begin
                     score_d[i] = sum[i][WIDTH] ? ScoreMax : sum[i][WIDTH-1:0];
                     combo_d[i] = (combo_q[i] >= ComboMax) ? ComboMax : combo_q[i] + ComboOne;
                  end
                  // A miss in the same cycle as a hit still breaks the streak.
                  if (player_missed[i]) begin
                     combo_d[i] = ComboOne;
                  end
               end
            end
         end
         StSettle: begin
            state_d = StShow;
            if (round_max > high_q) begin
               high_d     = round_max;
               new_high_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (reset) begin
         state_q    <= StIdle;
         leader_q   <= '0;
         high_q     <= '0;
         new_high_q <= 1'b0;
         for (int unsigned i = 0; i < NPLAY; i++) begin
            score_q[i] <= '0;
            combo_q[i] <= ComboOne;
         end
      end else begin
         state_q    <= state_d;
         leader_q   <= leader_d;
         high_q     <= high_d;
         new_high_q <= new_high_d;
         for (int unsigned i = 0; i < NPLAY; i++) begin
            score_q[i] <= score_d[i];
            combo_q[i] <= combo_d[i];
         end
      end
   end

   for (genvar g = 0; g < NPLAY; g++) begin : g_flat
      assign score[g*WIDTH +: WIDTH] = score_q[g];
      assign combo[g*MW +: MW]       = combo_q[g];
   end

   assign leader     = leader_q;
   assign high_score = high_q;
   assign new_high   = new_high_q;
   assign game_over  = (state_q == StShow);

endmodule

// File: tb/tb_score_tracker.sv
// Scoreboard bench: two score_tracker instances (8-bit and 4-bit scores) share
// random and directed stimulus; a behavioural model predicts every cycle.
module tb_score_tracker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       game_active = 1'b0;
   logic [1:0] player_scored = '0;
   logic [1:0] player_missed = '0;

   logic [15:0] sc8;
   logic [5:0]  cb8;
   logic        ld8;
   logic [7:0]  hs8;
   logic        nh8, go8;
   logic [7:0]  sc4;
   logic [5:0]  cb4;
   logic        ld4;
   logic [3:0]  hs4;
   logic        nh4, go4;

   always #5 clk = ~clk;

   score_tracker #(.WIDTH(8), .NPLAY(2), .COMBO_MAX(4)) dut8 (
      .clkIn(clk), .reset(reset), .game_active(game_active),
      .player_scored(player_scored), .player_missed(player_missed),
      .score(sc8), .combo(cb8), .leader(ld8), .high_score(hs8),
      .new_high(nh8), .game_over(go8)
   );

   score_tracker #(.WIDTH(4), .NPLAY(2), .COMBO_MAX(4)) dut4 (
      .clkIn(clk), .reset(reset), .game_active(game_active),
      .player_scored(player_scored), .player_missed(player_missed),
      .score(sc4), .combo(cb4), .leader(ld4), .high_score(hs4),
      .new_high(nh4), .game_over(go4)
   );

   typedef struct packed {
      logic [15:0] sc8;
      logic [7:0]  sc4;
      logic [5:0]  cb;
      logic        ld8;
      logic        ld4;
      logic [7:0]  hs8;
      logic [3:0]  hs4;
      logic        nh8;
      logic        nh4;
      logic        go;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Model state: phase 0=idle, 1=playing, 2=settling, 3=showing.
   int m_phase;
   int m_s8[2];
   int m_s4[2];
   int m_cb[2];
   int m_hs8, m_hs4, m_ld8, m_ld4;
   bit m_nh8, m_nh4;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   task automatic model_step(input bit r, input bit ga, input logic [1:0] h,
                             input logic [1:0] mi);
      int nl8, nl4, mx8, mx4;
      if (r) begin
         m_phase = 0;
         for (int p = 0; p < 2; p++) begin
            m_s8[p] = 0; m_s4[p] = 0; m_cb[p] = 1;
         end
         m_ld8 = 0; m_ld4 = 0; m_hs8 = 0; m_hs4 = 0; m_nh8 = 0; m_nh4 = 0;
         return;
      end
      nl8 = (m_s8[1] > m_s8[0]) ? 1 : 0;
      nl4 = (m_s4[1] > m_s4[0]) ? 1 : 0;
      mx8 = imax(m_s8[0], m_s8[1]);
      mx4 = imax(m_s4[0], m_s4[1]);
      m_nh8 = 0;
      m_nh4 = 0;
      case (m_phase)
         0, 3: begin
            if (ga) begin
               m_phase = 1;
               for (int p = 0; p < 2; p++) begin
                  m_s8[p] = 0; m_s4[p] = 0; m_cb[p] = 1;
               end
            end
         end
         1: begin
            if (!ga) begin
               m_phase = 2;
            end else begin
               for (int p = 0; p < 2; p++) begin
                  if (h[p]) begin
                     m_s8[p] = imin(m_s8[p] + m_cb[p], 255);
                     m_s4[p] = imin(m_s4[p] + m_cb[p], 15);
                  end
                  if (mi[p]) m_cb[p] = 1;
                  else if (h[p]) m_cb[p] = imin(m_cb[p] + 1, 4);
               end
            end
         end
         default: begin
            if (mx8 > m_hs8) begin m_hs8 = mx8; m_nh8 = 1; end
            if (mx4 > m_hs4) begin m_hs4 = mx4; m_nh4 = 1; end
            m_phase = 3;
         end
      endcase
      m_ld8 = nl8;
      m_ld4 = nl4;
   endtask

   task automatic cycle(input bit r, input bit ga, input logic [1:0] h, input logic [1:0] mi);
      exp_t e;
      reset         = r;
      game_active   = ga;
      player_scored = h;
      player_missed = mi;
      @(posedge clk);
      model_step(r, ga, h, mi);
      e.sc8 = {8'(m_s8[1]), 8'(m_s8[0])};
      e.sc4 = {4'(m_s4[1]), 4'(m_s4[0])};
      e.cb  = {3'(m_cb[1]), 3'(m_cb[0])};
      e.ld8 = 1'(m_ld8);
      e.ld4 = 1'(m_ld4);
      e.hs8 = 8'(m_hs8);
      e.hs4 = 4'(m_hs4);
      e.nh8 = m_nh8;
      e.nh4 = m_nh4;
      e.go  = (m_phase == 3);
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: outputs are presented every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("score8", 32'(sc8), 32'(e.sc8));
         chk("combo8", 32'(cb8), 32'(e.cb));
         chk("leader8", 32'(ld8), 32'(e.ld8));
         chk("high8", 32'(hs8), 32'(e.hs8));
         chk("new_high8", 32'(nh8), 32'(e.nh8));
         chk("game_over8", 32'(go8), 32'(e.go));
         chk("score4", 32'(sc4), 32'(e.sc4));
         chk("combo4", 32'(cb4), 32'(e.cb));
         chk("leader4", 32'(ld4), 32'(e.ld4));
         chk("high4", 32'(hs4), 32'(e.hs4));
         chk("new_high4", 32'(nh4), 32'(e.nh4));
         chk("game_over4", 32'(go4), 32'(e.go));
      end
   end

   initial begin
      // Reset and idle
      cycle(1, 0, 2'b00, 2'b00);
      cycle(1, 0, 2'b00, 2'b00);
      cycle(0, 0, 2'b01, 2'b00);
      cycle(0, 0, 2'b00, 2'b00);
      // Round 1: entry-cycle hit ignored, combo build-up, miss, simultaneous events
      cycle(0, 1, 2'b01, 2'b00);
      for (int i = 0; i < 5; i++) cycle(0, 1, 2'b01, 2'b00);
      cycle(0, 1, 2'b00, 2'b01);
      cycle(0, 1, 2'b01, 2'b00);
      cycle(0, 1, 2'b11, 2'b00);
      cycle(0, 1, 2'b10, 2'b00);
      cycle(0, 1, 2'b10, 2'b00);
      cycle(0, 1, 2'b10, 2'b10);
      cycle(0, 1, 2'b01, 2'b00);
      // Round end with a late hit that must be ignored
      cycle(0, 0, 2'b11, 2'b00);
      for (int i = 0; i < 4; i++) cycle(0, 0, 2'b01, 2'b00);
      // Round 2: lower final score, no new high
      cycle(0, 1, 2'b11, 2'b00);
      for (int i = 0; i < 3; i++) cycle(0, 1, 2'b01, 2'b00);
      cycle(0, 0, 2'b00, 2'b00);
      // game_active back during settle
      cycle(0, 1, 2'b00, 2'b00);
      cycle(0, 1, 2'b00, 2'b00);
      for (int i = 0; i < 30; i++) cycle(0, 1, 2'b11, 2'b00);
      cycle(0, 0, 2'b00, 2'b00);
      cycle(0, 0, 2'b00, 2'b00);
      cycle(0, 0, 2'b00, 2'b00);
      // Random rounds, with a mid-round reset in one of them
      for (int r = 0; r < 16; r++) begin
         int len;
         len = $urandom_range(20, 200);
         for (int c = 0; c < len; c++) begin
            logic [1:0] h, mi;
            h[0]  = ($urandom_range(0, 99) < 70);
            h[1]  = ($urandom_range(0, 99) < 60);
            mi[0] = ($urandom_range(0, 99) < 10);
            mi[1] = ($urandom_range(0, 99) < 10);
            cycle((r == 7 && c == len / 2), 1'b1, h, mi);
         end
         len = $urandom_range(1, 6);
         for (int c = 0; c < len; c++) cycle(0, 0, 2'($urandom), 2'($urandom));
      end
      cycle(0, 0, 2'b00, 2'b00);
      cycle(0, 0, 2'b00, 2'b00);
      @(negedge clk);
      @(negedge clk);
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
# score_tracker

Parametrised multi-player score engine for the mole-whacking game, replacing the single-player 6-bit counter. Tracks NPLAY independent saturating scores with per-player hit-streak combo multipliers. Keeps final scores visible after the round ends, maintains a session high score and reports the current leader. Sits between the per-player hit-detect logic and the display/scoreboard driver.

## Interface
- WIDTH, 8: score and high-score width; scores saturate at 2^WIDTH-1.
- NPLAY, 2: number of players (1..8).
- COMBO_MAX, 4: maximum combo multiplier (>=1); multiplier register width MW = $clog2(COMBO_MAX+1).
- clkIn  in  1  100 MHz system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- game_active  in  1  high while a round is running.
- player_scored  in  NPLAY  bit i = one-cycle valid hit pulse for player i.
- player_missed  in  NPLAY  bit i = one-cycle miss/timeout pulse for player i.
- score  out  NPLAY*WIDTH  player i score at [i*WIDTH +: WIDTH].
- combo  out  NPLAY*MW  player i current multiplier at [i*MW +: MW].
- leader  out  max(1,$clog2(NPLAY))  index of highest score; ties go to the lowest index.
- high_score  out  WIDTH  best single-player final score since reset.
- new_high  out  1  one-cycle pulse when high_score is raised.
- game_over  out  1  high while final scores are held for display.

## Operation
- FSM states: IDLE, PLAY, SETTLE, SHOW.
  - IDLE -> PLAY when game_active=1.
  - PLAY -> SETTLE when game_active=0.
  - SETTLE -> SHOW unconditionally, one cycle.
  - SHOW -> PLAY when game_active=1.
- Entry to PLAY (IDLE/SHOW with game_active=1): all scores cleared to 0, all multipliers set to 1. Hit/miss inputs are ignored in that cycle.
- Hit/miss inputs are acted on only while the state is PLAY and game_active=1. They are ignored in IDLE, SETTLE and SHOW.
- Per player i in PLAY:
  - Hit only: score += combo (saturating); combo <= min(combo+1, COMBO_MAX).
  - Miss only: combo <= 1; score unchanged.
  - Hit and miss together: score += combo; then combo <= 1.
  - Neither: hold.
- Saturating add: compute at WIDTH+1 bits and clamp to 2^WIDTH-1. Once at max, further hits leave score at max but still update combo.
- Players are fully independent; simultaneous hits from all players in one cycle are all applied.
- SETTLE: m = max over final scores. If m > high_score (strictly greater), high_score <= m and new_high <= 1 for exactly one cycle. Otherwise no change.
- SHOW: scores, combos and leader frozen; game_over=1.
- high_score persists across rounds; only reset clears it.
- leader is a registered maximum-index search over the registered scores, recomputed every cycle.

## Timing
- Reset (sync, active-high) forces, on the next edge: state=IDLE; all scores=0; all combos=1; leader=0; high_score=0; new_high=0; game_over=0. Reset has priority over every other input.
- Reset mid-round discards scores and high_score; the FSM returns to IDLE.
- Hit latency: a hit sampled at edge N appears on score at edge N (one-cycle registered update).
- leader lags score by one cycle.
- Round end:
  - game_active falls: sampled at edge N, state=SETTLE after N.
  - high_score/new_high valid after N+1, when game_over also rises.
  - new_high drops after N+2.
- A hit sampled in the same cycle that game_active=0 is first seen is ignored.
- game_active re-asserted during SETTLE: FSM still passes through SHOW for one cycle, then enters PLAY.

## Test plan
- Reset state: reset=1 for 2 cycles, NPLAY=2, WIDTH=8 -> score=0, combo=1/1, leader=0, high_score=0, new_high=0, game_over=0.
- Combo: player 0 hits on 5 consecutive cycles, COMBO_MAX=4 -> scores 1,3,6,10,14; combo 2,3,4,4,4. Then one miss -> combo=1, score=14. Then one hit -> score=15.
- Saturation: WIDTH=4, combo at 4, player at score 13; hit -> score=15 (not 17). Further hits keep score=15.
- Simultaneous events: both players hit in the same cycle -> both scores update. Player 1 hit+miss with combo=3 -> score +3, combo=1. Equal scores -> leader=0.
- Round end and high score: round ends at 22/9 -> one SETTLE cycle, then high_score=22, new_high pulses for 1 cycle, game_over=1, scores held. Next round ends at 20 -> no new_high, high_score stays 22.
- Restart: game_active rises in SHOW -> next cycle scores=0, combos=1, game_over=0. A hit pulsed in that entry cycle is ignored.
